// File: rtl/uart_buffered.sv
// Memory-mapped UART with RX/TX FIFOs, runtime baud divisor, interrupt mask and sticky error flags.
// Optional parity support is compiled in when UART_PARITY_EN is defined.
module uart_buffered #(
  parameter int DEFAULT_PRESCALE = 50000000 / (9600 * 8),
  parameter int RX_FIFO_DEPTH    = 256,
  parameter int TX_FIFO_DEPTH    = 16,
  parameter int DATA_BITS        = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int RX_AW = $clog2(RX_FIFO_DEPTH);
  localparam int TX_AW = $clog2(TX_FIFO_DEPTH);
  localparam int BW    = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // ---------------------------------------------------------------------------
  // Registers and bus decode
  // ---------------------------------------------------------------------------
  logic [15:0] ctrl_div;
  logic        rxie, txie;
  logic        paren, parodd;
  logic [3:0]  sticky;
  logic [3:0]  sticky_set;

  logic access, rd_access, wr_access;
  logic data_rd, status_rd, ctrl_wr, data_wr;

  assign access    = i_request && !o_ready;
  assign rd_access = access && !i_rw;
  assign wr_access = access && i_rw;
  assign data_rd   = rd_access && (i_address == 2'd0);
  assign status_rd = rd_access && (i_address == 2'd1);
  assign ctrl_wr   = wr_access && (i_address == 2'd2);
  assign data_wr   = wr_access && (i_address == 2'd0);

  logic unused_wdata;
  assign unused_wdata = ^i_wdata[31:18];

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_mem [RX_FIFO_DEPTH];
  logic [DATA_BITS-1:0] tx_mem [TX_FIFO_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp, rx_count;
  logic [TX_AW:0] tx_wp, tx_rp;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_ovr_set, tx_push, tx_pop, tx_ovr_set;
  logic [DATA_BITS-1:0] rx_head, tx_head, rx_shift;
  logic rx_byte_ok;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) && (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) && (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign rx_count = rx_wp - rx_rp;
  assign rx_head  = rx_mem[rx_rp[RX_AW-1:0]];
  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
  assign rx_pop     = data_rd && !rx_empty;
  assign rx_push    = rx_byte_ok && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_byte_ok && rx_full && !rx_pop;
  assign tx_push    = data_wr && (!tx_full || tx_pop);
  assign tx_ovr_set = data_wr && tx_full && !tx_pop;

  always_ff @(posedge i_clock) begin
    if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_shift;
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= i_wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud tick: a divisor change is only picked up at the next reload
  // ---------------------------------------------------------------------------
  logic [15:0] tick_cnt, div_eff;
  logic        tick;

  assign div_eff = (ctrl_div == 16'd0) ? 16'd1 : ctrl_div;
  assign tick    = (tick_cnt == 16'd0);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= div_eff - 16'd1;
    else tick_cnt <= tick_cnt - 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_sync1, rx_s, rx_prev, rx_fall;
  uart_state_t rx_state, rx_state_next;
  logic [2:0]    rx_tick_cnt;
  logic [BW-1:0] rx_bit_idx;
  logic rx_mid, rx_end, rx_par_bit, rx_par_en, rx_par_odd;
  logic rx_frame_err, rx_par_err;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= UART_RX;
      rx_s     <= rx_sync1;
      rx_prev  <= rx_s;
    end
  end

  assign rx_fall = rx_prev && !rx_s;
  assign rx_mid  = tick && (rx_tick_cnt == 3'd3);
  assign rx_end  = tick && (rx_tick_cnt == 3'd7);

  always_comb begin
    rx_state_next = rx_state;
    rx_byte_ok    = 1'b0;
    rx_frame_err  = 1'b0;
    rx_par_err    = 1'b0;
    case (rx_state)
      ST_IDLE:   if (rx_fall) rx_state_next = ST_START;
      ST_START: begin
        if (rx_mid && rx_s) rx_state_next = ST_IDLE;
        else if (rx_end) rx_state_next = ST_DATA;
      end
      ST_DATA:   if (rx_end && rx_bit_idx == LAST_BIT) rx_state_next = rx_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_end) rx_state_next = ST_STOP;
      ST_STOP: begin
        // Returning to idle mid-stop-bit leaves room to catch a back-to-back start edge.
        if (rx_mid) begin
          rx_state_next = ST_IDLE;
          if (!rx_s) rx_frame_err = 1'b1;
          else if (rx_par_en && (rx_par_bit != ((^rx_shift) ^ rx_par_odd))) rx_par_err = 1'b1;
          else rx_byte_ok = 1'b1;
        end
      end
      default:   rx_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_state    <= ST_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_idx  <= '0;
      rx_shift    <= '0;
      rx_par_bit  <= 1'b0;
      rx_par_en   <= 1'b0;
      rx_par_odd  <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      if (rx_state == ST_IDLE) begin
        rx_tick_cnt <= '0;
        rx_bit_idx  <= '0;
        rx_par_en   <= paren;
        rx_par_odd  <= parodd;
      end else if (tick) begin
        rx_tick_cnt <= rx_tick_cnt + 3'd1;
      end
      if (rx_state == ST_DATA && rx_mid) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
      if (rx_state == ST_DATA && rx_end) rx_bit_idx <= rx_bit_idx + 1'b1;
      if (rx_state == ST_PARITY && rx_mid) rx_par_bit <= rx_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter: frames start on a tick so every bit spans exactly 8 ticks
  // ---------------------------------------------------------------------------
  uart_state_t tx_state, tx_state_next;
  logic [2:0]    tx_tick_cnt;
  logic [BW-1:0] tx_bit_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic tx_end, tx_par_bit, tx_par_en, tx_line_next, tx_idle_empty;

  assign tx_end        = tick && (tx_tick_cnt == 3'd7);
  assign tx_idle_empty = tx_empty && (tx_state == ST_IDLE);

  always_comb begin
    tx_state_next = tx_state;
    tx_pop        = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (tick && !tx_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = ST_START;
        end
      end
      ST_START:  if (tx_end) tx_state_next = ST_DATA;
      ST_DATA:   if (tx_end && tx_bit_idx == LAST_BIT) tx_state_next = tx_par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tx_end) tx_state_next = ST_STOP;
      ST_STOP: begin
        if (tx_end) begin
          if (!tx_empty) begin
            tx_pop        = 1'b1;
            tx_state_next = ST_START;
          end else begin
            tx_state_next = ST_IDLE;
          end
        end
      end
      default:   tx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_line_next = 1'b1;
    case (tx_state_next)
      ST_START:  tx_line_next = 1'b0;
      ST_DATA:   tx_line_next = (tx_state == ST_DATA && tx_end) ? tx_shift[1] : tx_shift[0];
      ST_PARITY: tx_line_next = tx_par_bit;
      default:   tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tx_state    <= ST_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      UART_TX     <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      UART_TX  <= tx_line_next;
      if (tx_pop) begin
        tx_shift    <= tx_head;
        tx_par_bit  <= (^tx_head) ^ parodd;
        tx_par_en   <= paren;
        tx_tick_cnt <= '0;
        tx_bit_idx  <= '0;
      end else if (tx_state != ST_IDLE && tick) begin
        tx_tick_cnt <= tx_tick_cnt + 3'd1;
      end
      if (tx_state == ST_DATA && tx_end) begin
        tx_shift   <= tx_shift >> 1;
        tx_bit_idx <= tx_bit_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control register, sticky flags, read mux and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_div <= 16'(DEFAULT_PRESCALE);
      rxie     <= 1'b0;
      txie     <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_div <= i_wdata[15:0];
      rxie     <= i_wdata[16];
      txie     <= i_wdata[17];
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      paren  <= 1'b0;
      parodd <= 1'b0;
    end else if (ctrl_wr) begin
      paren  <= i_wdata[18];
      parodd <= i_wdata[19];
    end
  end
`else
  assign paren  = 1'b0;
  assign parodd = 1'b0;
`endif

  // A flag raised in the same cycle as the clearing STATUS read survives it.
  assign sticky_set = {tx_ovr_set, rx_par_err, rx_frame_err, rx_ovr_set};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) sticky <= '0;
    else sticky <= (sticky & ~{4{status_rd}}) | sticky_set;
  end

  logic [31:0] rx_count_wide, status_word, ctrl_word, read_mux;
  logic [15:0] rx_count_sat;

  assign rx_count_wide = 32'(rx_count);
  assign rx_count_sat  = (|rx_count_wide[31:16]) ? 16'hFFFF : rx_count_wide[15:0];
  assign status_word   = {8'h00, rx_count_sat, sticky, tx_full, tx_idle_empty, rx_full, !rx_empty};
  assign ctrl_word     = {12'h000, parodd, paren, txie, rxie, ctrl_div};

  always_comb begin
    read_mux = 32'h0;
    case (i_address)
      2'd0:    read_mux = rx_empty ? 32'h0 : 32'(rx_head);
      2'd1:    read_mux = status_word;
      2'd2:    read_mux = ctrl_word;
      default: read_mux = 32'h0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready     <= 1'b0;
      o_rdata     <= '0;
      o_interrupt <= 1'b0;
    end else begin
      o_ready     <= access;
      o_rdata     <= rd_access ? read_mux : 32'h0;
      o_interrupt <= (!rx_empty && rxie) || (tx_idle_empty && txie) || ((|sticky) && rxie);
    end
  end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: register table, TX frame capture, RX frame injection,
// FIFO overflow, error flags, interrupts and asynchronous reset.
module tb_uart_buffered;

  localparam int PRESC = 50000000 / (9600 * 8);
  localparam int BIT_CLKS = 32;
`ifdef UART_PARITY_EN
  localparam logic [31:0] CTRL_RB = 32'h000F_0004;
`else
  localparam logic [31:0] CTRL_RB = 32'h0003_0004;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_request = 1'b0;
  logic        i_rw = 1'b0;
  logic [1:0]  i_address = 2'd0;
  logic [31:0] i_wdata = 32'h0;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int checks = 0;
  int failures = 0;

  uart_buffered #(
    .DEFAULT_PRESCALE(PRESC),
    .RX_FIFO_DEPTH(4),
    .TX_FIFO_DEPTH(4),
    .DATA_BITS(8)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_request(i_request),
    .i_rw(i_rw),
    .i_address(i_address),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_ready(o_ready),
    .o_interrupt(o_interrupt),
    .UART_RX(uart_rx),
    .UART_TX(uart_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'h0;
    @(negedge clk);
    i_request = 1'b1;
    i_rw = rw;
    i_address = addr;
    i_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (o_ready) begin
        got = 1'b1;
        rdata = o_rdata;
      end
    end
    i_request = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL bus_timeout actual=no_ready expected=ready addr=%0d", addr);
    end
  endtask

  task automatic busRead(input logic [1:0] addr, input logic [31:0] expected, input string name);
    logic [31:0] r;
    applyStimulus(1'b0, addr, 32'h0, r);
    checkOutput(name, r, expected);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    logic [31:0] r;
    applyStimulus(1'b1, addr, data, r);
  endtask

  task automatic checkIrq(input string name, input logic expected);
    waitCycles(2);
    checkOutput(name, {31'h0, o_interrupt}, {31'h0, expected});
  endtask

  task automatic waitTxFall(output logic found);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx == 1'b0) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("[TB] FAIL tx_start_timeout actual=idle expected=start_bit");
    end
  endtask

  // Samples each bit at its centre, bit 0 of 'bits' being the first start bit.
  task automatic checkTxFrames(input logic [63:0] bits, input int n, input string name);
    logic found;
    waitTxFall(found);
    if (found) begin
      waitCycles(BIT_CLKS / 2);
      for (int i = 0; i < n; i++) begin
        if (i > 0) waitCycles(BIT_CLKS);
        checkOutput($sformatf("%s_bit%0d", name, i), {31'h0, uart_tx}, {31'h0, bits[i]});
      end
    end
  endtask

  task automatic sendRx(input logic [7:0] data, input logic par_en, input logic par_bit, input logic stop_bit);
    uart_rx = 1'b0;
    waitCycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      waitCycles(BIT_CLKS);
    end
    if (par_en) begin
      uart_rx = par_bit;
      waitCycles(BIT_CLKS);
    end
    uart_rx = stop_bit;
    waitCycles(BIT_CLKS);
    uart_rx = 1'b1;
    waitCycles(4);
  endtask

  initial begin
    logic [31:0] r;
    logic        found;
    logic [7:0]  rx_bytes [5];

    vecs[0]  = '{1'b0, 2'd2, 32'h0,         32'(PRESC),    1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0004, 1'b0};
    vecs[2]  = '{1'b0, 2'd3, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 2'd3, 32'h0,         32'h0,         1'b0};
    vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0004, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 32'h000F_0004, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 2'd2, 32'h0,         CTRL_RB,       1'b1};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_0004, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 2'd2, 32'h0,         32'h0000_0004, 1'b0};

    waitCycles(3);
    checkOutput("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    checkOutput("reset_ready", {31'h0, o_ready}, 32'h0);
    checkOutput("reset_rdata", o_rdata, 32'h0);
    checkOutput("reset_irq", {31'h0, o_interrupt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Held request: ready pulses, drops for one cycle, then a fresh access completes.
    @(negedge clk);
    i_request = 1'b1;
    i_rw = 1'b0;
    i_address = 2'd2;
    waitCycles(1);
    checkOutput("hold_ready0", {31'h0, o_ready}, 32'h1);
    checkOutput("hold_rdata0", o_rdata, 32'(PRESC));
    waitCycles(1);
    checkOutput("hold_ready1", {31'h0, o_ready}, 32'h0);
    waitCycles(1);
    checkOutput("hold_ready2", {31'h0, o_ready}, 32'h1);
    i_request = 1'b0;
    waitCycles(1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].wdata, r);
      if (!vecs[i].rw) checkOutput($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      checkIrq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // Two queued bytes go out back to back at 32 clocks per bit.
    busWrite(2'd0, 32'h0000_00A5);
    busWrite(2'd0, 32'h0000_003C);
    checkTxFrames({44'h0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}, 20, "tx_a5_3c");
    busRead(2'd1, 32'h0000_0000, "status_during_stop");
    waitCycles(BIT_CLKS);
    busRead(2'd1, 32'h0000_0004, "status_tx_done");

    sendRx(8'h5A, 1'b0, 1'b0, 1'b1);
    busRead(2'd1, 32'h0000_0105, "status_rx_one");
    busRead(2'd0, 32'h0000_005A, "data_rx_5a");
    busRead(2'd1, 32'h0000_0004, "status_rx_empty");

    rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) sendRx(rx_bytes[i], 1'b0, 1'b0, 1'b1);
    busRead(2'd1, 32'h0000_0417, "status_rx_overflow");
    busRead(2'd1, 32'h0000_0407, "status_rxovr_cleared");
    for (int i = 0; i < 4; i++) busRead(2'd0, 32'(rx_bytes[i]), $sformatf("data_fifo%0d", i));
    busRead(2'd0, 32'h0, "data_fifo_empty");
    busRead(2'd1, 32'h0000_0004, "status_fifo_drained");

    busWrite(2'd2, 32'h0001_0004);
    checkIrq("irq_rxie_idle", 1'b0);
    sendRx(8'h77, 1'b0, 1'b0, 1'b0);
    checkIrq("irq_framerr", 1'b1);
    busRead(2'd1, 32'h0000_0024, "status_framerr");
    checkIrq("irq_after_clear", 1'b0);
    busRead(2'd1, 32'h0000_0004, "status_framerr_cleared");

    uart_rx = 1'b0;
    waitCycles(4);
    uart_rx = 1'b1;
    waitCycles(400);
    busRead(2'd1, 32'h0000_0004, "status_glitch");
    checkIrq("irq_glitch", 1'b0);

    sendRx(8'h3C, 1'b0, 1'b0, 1'b1);
    checkIrq("irq_rxne", 1'b1);
    busRead(2'd0, 32'h0000_003C, "data_rx_3c");
    checkIrq("irq_rx_popped", 1'b0);

    busWrite(2'd2, 32'h0000_0004);
    for (int i = 0; i < 6; i++) busWrite(2'd0, 32'(8'h10 + i));
    busRead(2'd1, 32'h0000_0088, "status_tx_overflow");
    busRead(2'd1, 32'h0000_0008, "status_txovr_cleared");
    waitCycles(2000);
    busRead(2'd1, 32'h0000_0004, "status_tx_drained");

`ifdef UART_PARITY_EN
    busWrite(2'd2, 32'h000D_0004);
    busWrite(2'd0, 32'h0000_0001);
    checkTxFrames({53'h0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, "tx_par_odd");
    waitCycles(2 * BIT_CLKS);
    sendRx(8'h01, 1'b1, 1'b1, 1'b1);
    checkIrq("irq_parerr", 1'b1);
    busRead(2'd1, 32'h0000_0044, "status_parerr");
    sendRx(8'h01, 1'b1, 1'b0, 1'b1);
    busRead(2'd1, 32'h0000_0105, "status_par_ok");
    busRead(2'd0, 32'h0000_0001, "data_par_ok");
    busWrite(2'd2, 32'h0000_0004);
`endif

    // Asynchronous reset in the middle of an all-zero frame.
    busWrite(2'd0, 32'h0000_0000);
    busWrite(2'd0, 32'h0000_0000);
    waitTxFall(found);
    if (found) begin
      waitCycles(50);
      checkOutput("tx_mid_frame", {31'h0, uart_tx}, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("tx_async_reset", {31'h0, uart_tx}, 32'h1);
      waitCycles(2);
      @(negedge clk);
      rst_n = 1'b1;
      busRead(2'd1, 32'h0000_0004, "status_after_reset");
      busRead(2'd2, 32'(PRESC), "ctrl_after_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
